// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST sequencer: FSM states, shift-register
// modes and the default 7-bit tap masks for the benchmark netlists.
package bist_pkg;

  localparam int BIST_W = 7;

  localparam logic [BIST_W-1:0] BIST_LFSR_TAPS = 7'h60;
  localparam logic [BIST_W-1:0] BIST_MISR_TAPS = 7'h60;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    FLUSH = 3'd2,
    CMP   = 3'd3,
    DONE  = 3'd4
  } bist_state_e;

  typedef enum logic {
    MODE_GEN     = 1'b0,
    MODE_COMPACT = 1'b1
  } sr_mode_e;

endpackage

// File: rtl/bist_lfsr_misr.sv
// Shift register shared by the stimulus LFSR (MODE_GEN) and the response MISR
// (MODE_COMPACT); load has priority over a shift step.
module bist_lfsr_misr
  import bist_pkg::*;
#(
  parameter int               WIDTH   = BIST_W,
  parameter logic [WIDTH-1:0] TAPS    = WIDTH'(BIST_LFSR_TAPS),
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  sr_mode_e         mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] nxt;

  always_comb begin
    nxt = q;
    if (mode == MODE_GEN) begin
      nxt = {q[WIDTH-2:0], ^(q & TAPS)};
    end else begin
      nxt = {q[WIDTH-2:0], 1'b0} ^ (q[WIDTH-1] ? TAPS : '0) ^ din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/bist_seq_ctrl.sv
// BIST sequencer: LFSR stimulus into the CUT, MISR compaction of its response,
// golden-signature compare. Optional macro BIST_ZERO_PATTERN_EN prepends an all-zero pattern.
module bist_seq_ctrl
  import bist_pkg::*;
#(
  parameter int               WIDTH        = BIST_W,
  parameter int               NUM_PATTERNS = 127,
  parameter logic [WIDTH-1:0] LFSR_SEED    = WIDTH'(1),
  parameter logic [WIDTH-1:0] LFSR_TAPS    = WIDTH'(BIST_LFSR_TAPS),
  parameter logic [WIDTH-1:0] MISR_TAPS    = WIDTH'(BIST_MISR_TAPS),
  parameter logic [WIDTH-1:0] GOLDEN_SIG   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] cut_in,
  input  logic [WIDTH-1:0] cut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [7:0]       pattern_cnt
);

`ifdef BIST_ZERO_PATTERN_EN
  localparam int ZP = 1;
`else
  localparam int ZP = 0;
`endif

  localparam logic [WIDTH-1:0] SEED  = (LFSR_SEED == '0) ? WIDTH'(1) : LFSR_SEED;
  localparam logic [7:0]       TOTAL = 8'(NUM_PATTERNS + ZP);
  localparam logic [7:0]       LAST  = 8'(NUM_PATTERNS + ZP - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c >= TOTAL) ? TOTAL : c + 8'd1;
  endfunction

  bist_state_e      state;
  logic [WIDTH-1:0] stim_p0;
  logic             vld_p0;
  logic             zero_pend;
  logic [7:0]       cnt;
  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] misr_q;
  logic             run_start;
  logic             lfsr_en;

  assign run_start   = ((state == IDLE) || (state == DONE)) && start && !abort;
  assign lfsr_en     = (state == RUN) && !abort && !zero_pend;
  assign cut_in      = stim_p0;
  assign signature   = misr_q;
  assign pattern_cnt = cnt;

  bist_lfsr_misr #(
    .WIDTH   (WIDTH),
    .TAPS    (LFSR_TAPS),
    .RST_VAL (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .mode     (MODE_GEN),
    .load     (run_start),
    .load_val (SEED),
    .en       (lfsr_en),
    .din      ('0),
    .q        (lfsr_q)
  );

  // Response to the pattern held in stim_p0 is compacted on the following edge.
  bist_lfsr_misr #(
    .WIDTH   (WIDTH),
    .TAPS    (MISR_TAPS),
    .RST_VAL ('0)
  ) u_misr (
    .clk      (clk),
    .rst      (rst),
    .mode     (MODE_COMPACT),
    .load     (run_start),
    .load_val ('0),
    .en       (vld_p0),
    .din      (cut_out),
    .q        (misr_q)
  );

  // busy/done are decoded from the current state, so they trail the state by one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      stim_p0   <= '0;
      vld_p0    <= 1'b0;
      zero_pend <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else if (abort && (state inside {RUN, FLUSH, CMP})) begin
      state   <= IDLE;
      stim_p0 <= '0;
      vld_p0  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          vld_p0 <= 1'b0;
          busy   <= 1'b0;
          if (run_start) begin
            state     <= RUN;
            cnt       <= '0;
            zero_pend <= (ZP != 0);
            done      <= 1'b0;
            pass      <= 1'b0;
          end else begin
            done <= (state == DONE);
          end
        end
        RUN: begin
          busy      <= 1'b1;
          vld_p0    <= 1'b1;
          stim_p0   <= zero_pend ? '0 : lfsr_q;
          zero_pend <= 1'b0;
          cnt       <= sat_inc(cnt);
          if (cnt == LAST) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          busy   <= 1'b1;
          vld_p0 <= 1'b0;
          state  <= CMP;
        end
        CMP: begin
          busy  <= 1'b1;
          pass  <= (misr_q == GOLDEN_SIG);
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bist_seq_ctrl.sv
// Directed bench for bist_seq_ctrl: two short loopback runs (golden 04 / 05) and a
// full 127-pattern loopback run, plus abort, mid-run reset and start-while-busy cases.
module tb_bist_seq_ctrl;

  localparam int W = 7;
`ifdef BIST_ZERO_PATTERN_EN
  localparam int ZP = 1;
`else
  localparam int ZP = 0;
`endif
  localparam int NA = 3 + ZP;
  localparam int NC = 127 + ZP;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_a, abort_a, start_c;
  logic [W-1:0] cut_in_a, cut_in_b, cut_in_c;
  logic         busy_a, busy_b, busy_c;
  logic         done_a, done_b, done_c;
  logic         pass_a, pass_b, pass_c;
  logic [W-1:0] sig_a, sig_b, sig_c;
  logic [7:0]   cnt_a, cnt_b, cnt_c;

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] seq_a [0:3];

  always #5 clk = ~clk;

  bist_seq_ctrl #(.NUM_PATTERNS(3), .GOLDEN_SIG(7'h04)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
    .cut_in(cut_in_a), .cut_out(cut_in_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .signature(sig_a), .pattern_cnt(cnt_a)
  );

  bist_seq_ctrl #(.NUM_PATTERNS(3), .GOLDEN_SIG(7'h05)) dut_b (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
    .cut_in(cut_in_b), .cut_out(cut_in_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .signature(sig_b), .pattern_cnt(cnt_b)
  );

  bist_seq_ctrl #(.NUM_PATTERNS(127), .GOLDEN_SIG(7'h00)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .abort(1'b0),
    .cut_in(cut_in_c), .cut_out(cut_in_c), .busy(busy_c), .done(done_c),
    .pass(pass_c), .signature(sig_c), .pattern_cnt(cnt_c)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Short loopback run on dut_a/dut_b; a stray start at edge 2 must be ignored.
  task automatic run_a(input string tag);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int e = 1; e <= NA + 3; e++) begin
      start_a = (e == 2);
      tick();
      start_a = 1'b0;
      if (e <= NA) chk($sformatf("%s cut_in[%0d]", tag, e), 32'(cut_in_a), 32'(seq_a[e-1]));
      chk($sformatf("%s busy@%0d", tag, e), 32'(busy_a), 32'(e <= NA + 2));
      chk($sformatf("%s done@%0d", tag, e), 32'(done_a), 32'(e >= NA + 3));
    end
    chk({tag, " sig_a"}, 32'(sig_a), 32'h04);
    chk({tag, " sig_b"}, 32'(sig_b), 32'h04);
    chk({tag, " pass_a"}, 32'(pass_a), 32'd1);
    chk({tag, " pass_b"}, 32'(pass_b), 32'd0);
    chk({tag, " done_b"}, 32'(done_b), 32'd1);
    chk({tag, " busy_b"}, 32'(busy_b), 32'd0);
    chk({tag, " cnt_a"}, 32'(cnt_a), 32'(NA));
    chk({tag, " cnt_b"}, 32'(cnt_b), 32'(NA));
  endtask

  initial begin
    logic [W-1:0] lfsr_m;
    logic [W-1:0] misr_m;
    logic [W-1:0] p;
    logic [127:0] seen;
    int           dups;

    if (ZP != 0) begin
      seq_a[0] = 7'h00; seq_a[1] = 7'h01; seq_a[2] = 7'h02; seq_a[3] = 7'h04;
    end else begin
      seq_a[0] = 7'h01; seq_a[1] = 7'h02; seq_a[2] = 7'h04; seq_a[3] = 7'h00;
    end

    rst = 1'b1; start_a = 1'b0; abort_a = 1'b0; start_c = 1'b0;
    tick();
    tick();
    chk("rst cut_in", 32'(cut_in_a), 32'h0);
    chk("rst busy", 32'(busy_a), 32'd0);
    chk("rst done", 32'(done_a), 32'd0);
    chk("rst pass", 32'(pass_a), 32'd0);
    chk("rst sig", 32'(sig_a), 32'h0);
    chk("rst cnt", 32'(cnt_a), 32'h0);
    rst = 1'b0;
    tick();

    run_a("run1");

    // DONE holds its outputs until the next start
    repeat (3) tick();
    chk("hold done", 32'(done_a), 32'd1);
    chk("hold cut_in", 32'(cut_in_a), 32'h04);
    chk("hold pass", 32'(pass_a), 32'd1);

    // abort at the second RUN edge, together with start: abort wins
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    chk("abort pre cut_in", 32'(cut_in_a), 32'(seq_a[0]));
    abort_a = 1'b1;
    start_a = 1'b1;
    tick();
    abort_a = 1'b0;
    start_a = 1'b0;
    chk("abort busy", 32'(busy_a), 32'd0);
    chk("abort done", 32'(done_a), 32'd0);
    chk("abort pass", 32'(pass_a), 32'd0);
    chk("abort cut_in", 32'(cut_in_a), 32'h0);
    chk("abort sig", 32'(sig_a), 32'(seq_a[0]));
    tick();
    chk("abort idle busy", 32'(busy_a), 32'd0);
    chk("abort idle cut_in", 32'(cut_in_a), 32'h0);
    run_a("after_abort");

    // asynchronous reset in the middle of a run
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    chk("pre-rst cut_in", 32'(cut_in_a), 32'(seq_a[1]));
    #3 rst = 1'b1;
    #1;
    chk("async rst cut_in", 32'(cut_in_a), 32'h0);
    chk("async rst busy", 32'(busy_a), 32'd0);
    chk("async rst sig", 32'(sig_a), 32'h0);
    chk("async rst cnt", 32'(cnt_a), 32'h0);
    #2 rst = 1'b0;
    run_a("after_rst");

    // full-length loopback run on dut_c
    lfsr_m = 7'h01;
    misr_m = '0;
    seen   = '0;
    dups   = 0;
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    for (int e = 1; e <= NC; e++) begin
      tick();
      if (ZP != 0 && e == 1) begin
        p = '0;
      end else begin
        p = lfsr_m;
        lfsr_m = {lfsr_m[5:0], lfsr_m[6] ^ lfsr_m[5]};
      end
      chk($sformatf("long cut_in[%0d]", e), 32'(cut_in_c), 32'(p));
      if (seen[cut_in_c]) dups++;
      seen[cut_in_c] = 1'b1;
      misr_m = {misr_m[5:0], 1'b0} ^ (misr_m[6] ? 7'h60 : 7'h00) ^ p;
    end
    repeat (3) tick();
    chk("long dup patterns", 32'(dups), 32'd0);
    chk("long distinct nonzero", 32'($countones(seen[127:1])), 32'd127);
    chk("long zero applied", 32'(seen[0]), 32'(ZP));
    chk("long cnt", 32'(cnt_c), 32'(NC));
    chk("long done", 32'(done_c), 32'd1);
    chk("long busy", 32'(busy_c), 32'd0);
    chk("long sig", 32'(sig_c), 32'(misr_m));
    chk("long pass", 32'(pass_c), 32'(misr_m == 7'h00));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
